// File: rtl/nav_move_scheduler.sv
// nav_move_scheduler: turns per-lane spike edges and sensor move commands into
// a single stream of moves for the position accumulator.
//  - spike rising edges are counted per lane in 3-bit saturating counters
//  - a 5-way round-robin arbiter (lanes 0-3, command port 4) picks the next move
//  - a two-state FSM (IDLE/ISSUE) presents one move at a time with valid/ready
// Optional feature: define NAV_SPIKE_COALESCE_EN to issue a lane's whole pending
// count as one move instead of one move per spike.
module nav_move_scheduler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [3:0]  spike_in,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_dir,
    input  logic [15:0] cmd_mag,
    output logic        cmd_ready,
    output logic        move_valid,
    output logic [1:0]  move_dir,
    output logic [15:0] move_mag,
    input  logic        move_ready,
    input  logic        clear_ovf,
    output logic [3:0]  ovf,
    output logic        irq,
    output logic        busy
);

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [3:0]       spike_prev;
    logic [3:0]       rise;
    logic [3:0][2:0]  pending, pending_nxt;
    logic [2:0]       last_grant, last_grant_nxt;
    logic [3:0]       ovf_set, ovf_nxt;
    logic [4:0]       req;
    logic             any_req;
    logic [2:0]       winner;
    logic [3:0]       consume;
    logic [1:0]       move_dir_nxt;
    logic [15:0]      move_mag_nxt;
    logic [15:0]      lane_mag;

    assign rise = spike_in & ~spike_prev;

    // requesters: lanes with a non-zero count, plus the command port
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req[i] = (pending[i] != 3'd0);
        end
        req[4] = cmd_valid;
    end

    assign any_req = |req;

`ifdef NAV_SPIKE_COALESCE_EN
    // coalesced magnitude: stored count plus this cycle's rise, capped at 7
    logic [3:0][2:0] coal_cnt;
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            coal_cnt[i] = (pending[i] == 3'd7) ? 3'd7 : (pending[i] + {2'b00, rise[i]});
        end
    end
    assign lane_mag = {13'd0, coal_cnt[winner[1:0]]};
`else
    assign lane_mag = 16'd1;
`endif

    // round-robin search starting one past the previous winner
    always_comb begin
        logic found;
        winner = 3'd0;
        found  = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            int idx;
            idx = (int'(last_grant) + k) % 5;
            if (!found && req[3'(idx)]) begin
                winner = 3'(idx);
                found  = 1'b1;
            end
        end
    end

    // FSM next state, grant decision and move register loads
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        move_dir_nxt   = move_dir;
        move_mag_nxt   = move_mag;
        consume        = 4'b0000;
        cmd_ready      = 1'b0;
        case (state)
            IDLE: begin
                if (enable && any_req) begin
                    last_grant_nxt = winner;
                    if (winner == 3'd4) begin
                        // gate with rst_n so the port never acks during reset
                        cmd_ready = rst_n;
                        // zero-magnitude commands are consumed without a move
                        if (cmd_mag != 16'd0) begin
                            state_nxt    = ISSUE;
                            move_dir_nxt = cmd_dir;
                            move_mag_nxt = cmd_mag;
                        end
                    end else begin
                        consume[winner[1:0]] = 1'b1;
                        state_nxt            = ISSUE;
                        move_dir_nxt         = winner[1:0];
                        move_mag_nxt         = lane_mag;
                    end
                end
            end
            ISSUE: begin
                if (move_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // pending counter update and overflow detection
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            ovf_set[i]     = 1'b0;
            pending_nxt[i] = pending[i];
            if (consume[i]) begin
`ifdef NAV_SPIKE_COALESCE_EN
                pending_nxt[i] = 3'd0;
`else
                // granted lanes have pending >= 1, so this cannot wrap
                pending_nxt[i] = pending[i] + {2'b00, rise[i]} - 3'd1;
`endif
            end else if (rise[i]) begin
                if (pending[i] == 3'd7) begin
                    ovf_set[i] = 1'b1;
                end else begin
                    pending_nxt[i] = pending[i] + 3'd1;
                end
            end
        end
        // a fresh overflow beats a simultaneous clear
        ovf_nxt = (clear_ovf ? 4'b0000 : ovf) | ovf_set;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // datapath registers: spike history, counters, arbiter pointer, move, flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_prev <= 4'b0000;
            pending    <= '0;
            last_grant <= 3'd4;
            move_dir   <= 2'd0;
            move_mag   <= 16'd0;
            ovf        <= 4'b0000;
        end else begin
            spike_prev <= spike_in;
            pending    <= pending_nxt;
            last_grant <= last_grant_nxt;
            move_dir   <= move_dir_nxt;
            move_mag   <= move_mag_nxt;
            ovf        <= ovf_nxt;
        end
    end

    assign move_valid = (state == ISSUE);
    assign busy       = (state == ISSUE);
    assign irq        = |ovf;

endmodule

// File: tb/tb_nav_move_scheduler.sv
// Scoreboard bench for nav_move_scheduler: a behavioural model pushes expected
// moves into a queue; a negedge monitor compares every presented move and the
// per-cycle status outputs. Directed phases followed by random stimulus.
module tb_nav_move_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  spike_in = 4'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_dir = 2'd0;
    logic [15:0] cmd_mag = 16'd0;
    logic        cmd_ready;
    logic        move_valid;
    logic [1:0]  move_dir;
    logic [15:0] move_mag;
    logic        move_ready = 1'b0;
    logic        clear_ovf = 1'b0;
    logic [3:0]  ovf;
    logic        irq;
    logic        busy;

    nav_move_scheduler dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .spike_in(spike_in),
        .cmd_valid(cmd_valid), .cmd_dir(cmd_dir), .cmd_mag(cmd_mag),
        .cmd_ready(cmd_ready), .move_valid(move_valid), .move_dir(move_dir),
        .move_mag(move_mag), .move_ready(move_ready), .clear_ovf(clear_ovf),
        .ovf(ovf), .irq(irq), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  dir;
        logic [15:0] mag;
    } mv_t;

    int       n_vec = 0;
    int       n_err = 0;
    int       m_pend [4];
    bit [3:0] m_prev;
    bit [3:0] m_ovf;
    int       m_last = 4;
    bit       m_busy;
    int       m_cmd_acc = 0;
    mv_t      exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // first requester found scanning upward from last+1, wrapping at 5
    function automatic int pick(input int last, input bit [4:0] rq);
        for (int k = 1; k <= 5; k++) begin
            if (rq[(last + k) % 5]) return (last + k) % 5;
        end
        return -1;
    endfunction

    function automatic bit [4:0] model_req();
        bit [4:0] r;
        for (int i = 0; i < 4; i++) r[i] = (m_pend[i] != 0);
        r[4] = cmd_valid;
        return r;
    endfunction

    // reference model: one update per clock edge, computed from the rules
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_pend[i] = 0;
            m_prev = 4'b0;
            m_ovf  = 4'b0;
            m_last = 4;
            m_busy = 1'b0;
            exp_q.delete();
        end else begin
            bit [3:0] rise;
            bit [3:0] take;
            bit [3:0] oset;
            int       w;
            int       mag;
            mv_t      mv;
            rise = spike_in & ~m_prev;
            take = 4'b0;
            oset = 4'b0;
            if (m_busy) begin
                if (move_ready) m_busy = 1'b0;
            end else if (enable) begin
                w = pick(m_last, model_req());
                if (w >= 0) begin
                    m_last = w;
                    if (w == 4) begin
                        m_cmd_acc++;
                        if (cmd_mag != 0) begin
                            mv.dir = cmd_dir;
                            mv.mag = cmd_mag;
                            exp_q.push_back(mv);
                            m_busy = 1'b1;
                        end
                    end else begin
                        take[w] = 1'b1;
`ifdef NAV_SPIKE_COALESCE_EN
                        mag = m_pend[w] + int'(rise[w]);
                        if (mag > 7) mag = 7;
`else
                        mag = 1;
`endif
                        mv.dir = 2'(w);
                        mv.mag = 16'(mag);
                        exp_q.push_back(mv);
                        m_busy = 1'b1;
                    end
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (take[i]) begin
`ifdef NAV_SPIKE_COALESCE_EN
                    m_pend[i] = 0;
`else
                    m_pend[i] = m_pend[i] + int'(rise[i]) - 1;
`endif
                end else if (rise[i]) begin
                    if (m_pend[i] == 7) oset[i] = 1'b1;
                    else m_pend[i] = m_pend[i] + 1;
                end
            end
            m_ovf  = (clear_ovf ? 4'b0 : m_ovf) | oset;
            m_prev = spike_in;
        end
    end

    // monitor: status every cycle, move contents against the scoreboard head
    always @(negedge clk) begin
        logic exp_cr;
        exp_cr = rst_n && !m_busy && enable && cmd_valid && (pick(m_last, model_req()) == 4);
        chk("move_valid", move_valid, m_busy);
        chk("busy", busy, m_busy);
        chk("ovf", ovf, m_ovf);
        chk("irq", irq, |m_ovf);
        chk("cmd_ready", cmd_ready, exp_cr);
        if (move_valid) begin
            if (exp_q.size() == 0) begin
                chk("move_unexpected", 1, 0);
            end else begin
                chk("move_dir", move_dir, exp_q[0].dir);
                chk("move_mag", move_mag, exp_q[0].mag);
                if (move_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse_spike(input int lane);
        spike_in[lane] = 1'b1;
        tick();
        spike_in[lane] = 1'b0;
        tick();
    endtask

    task automatic wait_cmd_taken(input int start_cnt, input int budget);
        int n;
        n = 0;
        while (m_cmd_acc == start_cnt && n < budget) begin
            tick();
            n++;
        end
        if (m_cmd_acc == start_cnt) chk("cmd_accept_timeout", 0, 1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        bit left;
        n = 0;
        left = 1'b1;
        while (left && n < budget) begin
            left = m_busy || (exp_q.size() != 0);
            for (int i = 0; i < 4; i++) if (m_pend[i] != 0) left = 1'b1;
            if (left) begin
                tick();
                n++;
            end
        end
        if (left) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        int c0;
        // reset: cmd_ready must stay low even with a request offered
        enable    = 1'b1;
        cmd_valid = 1'b1;
        cmd_mag   = 16'h0007;
        tick();
        tick();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_move_valid", move_valid, 0);
        cmd_valid = 1'b0;
        rst_n     = 1'b1;
        tick();

        // single lane0 rise -> move two edges later, dir 0
        move_ready = 1'b0;
        spike_in[0] = 1'b1;
        tick();
        spike_in[0] = 1'b0;
        chk("l0_not_yet", move_valid, 0);
        tick();
        chk("l0_valid", move_valid, 1);
        chk("l0_dir", move_dir, 0);
        move_ready = 1'b1;
        tick();
        move_ready = 1'b0;
        chk("l0_done", move_valid, 0);

        // all lanes pending plus a command: lanes 0..3 then cmd
        do_reset();
        enable   = 1'b0;
        spike_in = 4'hF;
        tick();
        spike_in = 4'h0;
        tick();
        cmd_valid  = 1'b1;
        cmd_dir    = 2'd2;
        cmd_mag    = 16'h0123;
        enable     = 1'b1;
        move_ready = 1'b1;
        c0 = m_cmd_acc;
        wait_cmd_taken(c0, 40);
        wait_idle(40);

        // nine rises on lane1 while disabled -> saturation and overflow
        do_reset();
        enable     = 1'b0;
        move_ready = 1'b0;
        for (int i = 0; i < 9; i++) pulse_spike(1);
        chk("ovf_lane1", ovf, 4'b0010);
        chk("irq_set", irq, 1);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        chk("ovf_cleared", ovf, 0);
        enable     = 1'b1;
        move_ready = 1'b1;
        wait_idle(40);

        // stall with move_ready low; a command waits for IDLE
        move_ready = 1'b0;
        pulse_spike(2);
        cmd_valid = 1'b1;
        cmd_dir   = 2'd3;
        cmd_mag   = 16'h0055;
        c0 = m_cmd_acc;
        repeat (10) tick();
        chk("stall_cmd_ready", cmd_ready, 0);
        chk("stall_dir", move_dir, 2);
        move_ready = 1'b1;
        wait_cmd_taken(c0, 20);
        wait_idle(20);

        // zero-magnitude command is acked without a move
        cmd_valid = 1'b1;
        cmd_dir   = 2'd1;
        cmd_mag   = 16'h0000;
        c0 = m_cmd_acc;
        #3;
        chk("zero_cmd_ready", cmd_ready, 1);
        wait_cmd_taken(c0, 5);
        tick();
        chk("zero_cmd_nomove", move_valid, 0);

        // reset in the middle of an issued move
        move_ready = 1'b0;
        pulse_spike(3);
        spike_in = 4'hF;
        tick();
        spike_in = 4'h0;
        #3 rst_n = 1'b0;
        #1;
        chk("arst_move_valid", move_valid, 0);
        chk("arst_busy", busy, 0);
        tick();
        rst_n      = 1'b1;
        move_ready = 1'b1;
        repeat (5) tick();

        // randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            spike_in   = 4'($urandom);
            enable     = ($urandom_range(0, 9) < 4);
            cmd_valid  = ($urandom_range(0, 3) == 0);
            cmd_dir    = 2'($urandom);
            cmd_mag    = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            move_ready = 1'($urandom_range(0, 1));
            clear_ovf  = ($urandom_range(0, 15) == 0);
            if (cyc == 1500) begin
                #2 rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            tick();
        end

        // drain
        spike_in   = 4'h0;
        cmd_valid  = 1'b0;
        clear_ovf  = 1'b0;
        enable     = 1'b0;
        move_ready = 1'b1;
        repeat (4) tick();
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nav_move_scheduler.md
NAV_MOVE_SCHEDULER -- requirements
Module: nav_move_scheduler

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port enable, input, 1 bit: when high, new grants may start.
REQ-004 SHALL have port spike_in, input, 4 bits: spike lanes; lane0 +X, lane1 +Y, lane2 -X, lane3 -Y.
REQ-005 SHALL have port cmd_valid, input, 1 bit: a sensor move command is offered.
REQ-006 SHALL have port cmd_dir, input, 2 bits: command direction; 0 +X, 1 +Y, 2 -X, 3 -Y.
REQ-007 SHALL have port cmd_mag, input, 16 bits: command magnitude.
REQ-008 SHALL have port cmd_ready, output, 1 bit: command accepted in this cycle.
REQ-009 SHALL have port move_valid, output, 1 bit: a move is presented to the position accumulator.
REQ-010 SHALL have port move_dir, output, 2 bits: direction of the presented move.
REQ-011 SHALL have port move_mag, output, 16 bits: magnitude of the presented move.
REQ-012 SHALL have port move_ready, input, 1 bit: the accumulator accepts the presented move.
REQ-013 SHALL have port clear_ovf, input, 1 bit: pulse that clears the overflow flags.
REQ-014 SHALL have port ovf, output, 4 bits: sticky per-lane pending-count overflow flags.
REQ-015 SHALL have port irq, output, 1 bit: OR of ovf.
REQ-016 SHALL have port busy, output, 1 bit: high while the state is ISSUE.

Function
REQ-017 SHALL register spike_in each cycle into a previous-value register.
- rise[i] = spike_in[i] AND NOT previous[i].
REQ-018 SHALL keep a 3-bit saturating pending counter per lane.
- Each edge: pending <= pending + rise - consume.
- Rise and consume in the same cycle SHALL leave the count unchanged.
REQ-019 SHALL, on a rise while pending==7 and no consume, hold pending at 7 and set ovf[i].
REQ-020 SHALL keep ovf set until a clear_ovf pulse; when clear_ovf and a new overflow coincide, the new overflow SHALL win.
REQ-021 SHALL implement a two-state FSM, IDLE and ISSUE; reset state is IDLE.
REQ-022 SHALL arbitrate round-robin over 5 requesters: lanes 0-3 and the command port (index 4).
- Requester i requests when pending[i]!=0; the command port requests when cmd_valid=1.
- The search starts at last_grant+1 mod 5.
REQ-023 SHALL, in IDLE with enable=1 and at least one request:
- grant the winner;
- update last_grant;
- load move_dir and move_mag;
- go to ISSUE on the next edge, so move_valid rises one cycle after the grant.
REQ-024 SHALL make cmd_ready combinational: high only in IDLE, with enable=1 and cmd_valid=1, when the command port wins.
REQ-025 SHALL, for a command grant, load move_dir=cmd_dir and move_mag=cmd_mag.
REQ-026 SHALL, for a command with cmd_mag=0, consume the command (cmd_ready=1), issue no move, stay in IDLE, and still update last_grant.
REQ-027 SHALL, for a lane grant, load move_dir=lane index and consume per REQ-043/REQ-044.
REQ-028 SHALL hold move_valid, move_dir and move_mag stable in ISSUE until move_valid and move_ready are both high.
- That edge returns the FSM to IDLE and drops move_valid.
- No back-to-back issue: minimum 2 cycles per move.
REQ-029 SHALL let a grant in ISSUE complete when enable drops; pending counters SHALL keep accumulating while enable=0.
REQ-030 SHALL ignore move_ready in IDLE.
REQ-031 SHALL drive busy = (state==ISSUE) and move_valid = (state==ISSUE).

Reset
REQ-032 SHALL asynchronously force the following while rst_n=0:
- state IDLE, last_grant=4;
- all pending counters 0, previous spike register 0;
- move_valid 0, move_dir 0, move_mag 0;
- ovf 0, irq 0, busy 0.
REQ-033 SHALL abandon any move in flight at reset, with no completion.
REQ-034 SHALL hold cmd_ready at 0 during reset.

Configuration
REQ-035 SHALL compile spike coalescing in when macro NAV_SPIKE_COALESCE_EN is defined.
REQ-036 SHALL, with NAV_SPIKE_COALESCE_EN defined, on a lane grant:
- set move_mag to the zero-extended pending count, including any rise in the grant cycle, saturated at 7;
- clear that lane's pending counter to 0.
REQ-037 SHALL, without NAV_SPIKE_COALESCE_EN, on a lane grant set move_mag=1 and decrement that lane's pending counter by 1.

Verification
REQ-038 SHALL cover: reset, then a rise on lane0 -> move_valid high 2 cycles after the rise edge with dir 0, mag 1; move_ready=1 -> back to IDLE.
REQ-039 SHALL cover: cmd_valid with dir 2, mag 0x0123 and all lanes pending -> grant order lane0, lane1, lane2, lane3, cmd (from last_grant=4), each held until move_ready.
REQ-040 SHALL cover: 9 rises on lane1 while enable=0 -> pending 7, ovf=0010, irq=1; clear_ovf -> ovf 0; then enable -> 7 moves (non-coalesced) or one move with mag 7 (coalesced).
REQ-041 SHALL cover: move_ready held low 10 cycles -> move_valid, move_dir and move_mag stable; a cmd arriving meanwhile -> cmd_ready stays 0 until IDLE.
REQ-042 SHALL cover: cmd with mag 0 -> one cycle of cmd_ready, no move_valid; and rst_n pulled low during ISSUE -> move_valid 0 immediately, pending counts 0.

Function (lane consumption)
REQ-043 SHALL, without NAV_SPIKE_COALESCE_EN, consume one pending count per lane grant.
REQ-044 SHALL, with NAV_SPIKE_COALESCE_EN, consume the whole pending count per lane grant.
